// File: rtl/fix_session_engine_if.sv
// fix_session_engine_if: inbound message, local command and outbound request handshakes.
interface fix_session_engine_if #(parameter int HOST_W = 3);
   logic msg_valid_i, msg_ready_o, resend_done_i;
   logic [HOST_W-1:0] msg_host_i;
   logic [2:0] msg_type_i, msg_validity_i;
   logic cmd_valid_i, cmd_ready_o, cmd_op_i;
   logic [HOST_W-1:0] cmd_host_i;
   logic req_valid_o, req_ready_i;
   logic [2:0] req_type_o;
   logic [HOST_W-1:0] req_host_o;
   modport slave (
      input msg_valid_i, msg_host_i, msg_type_i, msg_validity_i, resend_done_i,
      input cmd_valid_i, cmd_host_i, cmd_op_i, req_ready_i,
      output msg_ready_o, cmd_ready_o, req_valid_o, req_type_o, req_host_o
   );
   modport master (
      output msg_valid_i, msg_host_i, msg_type_i, msg_validity_i, resend_done_i,
      output cmd_valid_i, cmd_host_i, cmd_op_i, req_ready_i,
      input msg_ready_o, cmd_ready_o, req_valid_o, req_type_o, req_host_o
   );
endinterface

// File: rtl/fix_session_engine.sv
// fix_session_engine: multi-session FIX session state, heartbeat timers and outbound request queue.
module fix_session_engine #(
   parameter int NUM_SESSIONS = 8,
   parameter int HOST_W = 3,
   parameter int HB_INTERVAL = 30,
   parameter int REQ_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   fix_session_engine_if.slave bus,
   input  logic tick_i,
   output logic disconnect_o,
   output logic [HOST_W-1:0] disconnect_host_o,
   output logic fatal_o,
   output logic ignore_o,
   output logic deliver_o,
   output logic do_resend_o,
   output logic update_seq_o,
   output logic [HOST_W-1:0] event_host_o,
   input  logic [HOST_W-1:0] query_host_i,
   output logic [2:0] query_state_o
);
   typedef enum logic [2:0] {DISC, LOGON_SENT, ACTIVE, HB_SENT, RESEND, RESEND_LOGOUT, LOGOUT_SENT} state_t;
   localparam int AW = $clog2(REQ_DEPTH);
   localparam logic [7:0] HB = 8'(HB_INTERVAL);
   state_t st [NUM_SESSIONS];
   state_t cs, ns;
   logic [7:0] tmr [NUM_SESSIONS];
   logic [NUM_SESSIONS-1:0] pend;
   logic [HOST_W-1:0] ptr, sel, idx, eh;
   logic [HOST_W+2:0] mem [REQ_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic [2:0] ptype, t, v;
   logic full, pop, push, found, msg_acc, cmd_acc, to_acc, acc, rl, dis, fat, ign, dlv, rsd, upd, hi;
   assign t = bus.msg_type_i;
   assign v = bus.msg_validity_i;
   assign hi = v == 3'd1;
   assign full = cnt == (AW+1)'(REQ_DEPTH);
   assign pop = bus.req_valid_o & bus.req_ready_i;
   assign bus.msg_ready_o = rst & ~full;
   assign bus.cmd_ready_o = rst & ~full & ~bus.msg_valid_i;
   assign bus.req_valid_o = cnt != '0;
   assign {bus.req_type_o, bus.req_host_o} = bus.req_valid_o ? mem[rp] : '0;
   assign query_state_o = st[query_host_i];
   assign msg_acc = bus.msg_ready_o & bus.msg_valid_i;
   assign cmd_acc = bus.cmd_ready_o & bus.cmd_valid_i;
   assign to_acc = bus.cmd_ready_o & ~bus.cmd_valid_i & |pend;
   assign acc = msg_acc | cmd_acc | to_acc;
   assign eh = msg_acc ? bus.msg_host_i : cmd_acc ? bus.cmd_host_i : sel;
   assign cs = st[eh];
   // Round-robin timeout pick: first pending session at or after ptr.
   always_comb begin
      sel = '0;
      idx = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_SESSIONS; i++) begin
         idx = HOST_W'((int'(ptr) + i) % NUM_SESSIONS);
         if (!found && pend[idx]) begin
            found = 1'b1;
            sel = idx;
         end
      end
   end
   always_comb begin
      ns = cs;
      push = 1'b0;
      ptype = 3'd0;
      rl = 1'b0;
      dis = 1'b0;
      fat = 1'b0;
      ign = 1'b0;
      dlv = 1'b0;
      rsd = 1'b0;
      upd = 1'b0;
      if (msg_acc) begin
         if (cs == DISC) ign = 1'b1;
         else if (v >= 3'd3) begin
            dis = 1'b1;
            fat = 1'b1;
            ns = DISC;
         end else if (v == 3'd2) ign = 1'b1;
         else begin
            rl = 1'b1;
            if (cs == LOGON_SENT) begin
               push = t == 3'd1 && hi;
               ptype = 3'd3;
               dis = t != 3'd1;
               ns = t != 3'd1 ? DISC : hi ? RESEND : ACTIVE;
            end else if (cs == ACTIVE || cs == HB_SENT) begin
               if (t == 3'd4 && !hi) begin
                  push = 1'b1;
                  ptype = 3'd4;
                  dis = 1'b1;
                  ns = DISC;
               end else if (t == 3'd3) begin
                  rsd = 1'b1;
                  ns = ACTIVE;
               end else if (hi) begin
                  push = 1'b1;
                  ptype = 3'd3;
                  ns = t == 3'd4 ? RESEND_LOGOUT : RESEND;
               end else begin
                  dlv = t == 3'd7;
                  ns = ACTIVE;
               end
            end else if (cs == RESEND || cs == RESEND_LOGOUT) begin
               upd = t == 3'd5 || t == 3'd6;
               dlv = t == 3'd7;
               push = bus.resend_done_i ? cs == RESEND_LOGOUT : hi && t != 3'd5;
               ptype = bus.resend_done_i ? 3'd4 : 3'd3;
               ns = !bus.resend_done_i ? cs : cs == RESEND ? ACTIVE : LOGOUT_SENT;
            end else begin
               rsd = t == 3'd3;
               dis = t != 3'd3;
               ns = t == 3'd3 ? cs : DISC;
            end
         end
      end else if (cmd_acc) begin
         push = !bus.cmd_op_i || cs != DISC;
         ptype = bus.cmd_op_i ? 3'd4 : 3'd1;
         rl = push;
         ns = !bus.cmd_op_i ? LOGON_SENT : cs == DISC ? DISC : LOGOUT_SENT;
      end else if (to_acc) begin
         rl = 1'b1;
         push = cs == ACTIVE || cs == RESEND || cs == RESEND_LOGOUT;
         ptype = 3'd2;
         dis = !push;
         ns = cs == ACTIVE ? HB_SENT : push ? cs : DISC;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SESSIONS; i++) begin
            st[i] <= DISC;
            tmr[i] <= 8'd0;
         end
         pend <= '0;
         ptr <= '0;
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         {disconnect_o, fatal_o, ignore_o, deliver_o, do_resend_o, update_seq_o} <= '0;
         disconnect_host_o <= '0;
         event_host_o <= '0;
      end else begin
         // A garbled message neither reloads nor forgets an already expired timer.
         for (int i = 0; i < NUM_SESSIONS; i++)
            if (acc && eh == HOST_W'(i)) begin
               st[i] <= ns;
               tmr[i] <= ns == DISC ? 8'd0 : rl ? HB : (tick_i && tmr[i] != 8'd0) ? tmr[i] - 8'd1 : tmr[i];
               pend[i] <= ns != DISC && !rl && (tmr[i] == 8'd0 ? pend[i] : tick_i && tmr[i] == 8'd1);
            end else if (tick_i && st[i] != DISC && tmr[i] != 8'd0) begin
               tmr[i] <= tmr[i] - 8'd1;
               pend[i] <= pend[i] | (tmr[i] == 8'd1);
            end
         if (to_acc) ptr <= HOST_W'((int'(sel) + 1) % NUM_SESSIONS);
         disconnect_o <= dis;
         fatal_o <= fat;
         disconnect_host_o <= dis ? eh : '0;
         ignore_o <= ign;
         deliver_o <= dlv;
         do_resend_o <= rsd;
         update_seq_o <= upd;
         event_host_o <= (ign | dlv | rsd | upd) ? eh : '0;
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wp] <= {ptype, eh};
endmodule

// File: tb/tb_fix_session_engine.sv
// tb_fix_session_engine: table of message vectors on one session plus hand-written multi-cycle sequences.
module tb_fix_session_engine;
   typedef struct {
      logic [2:0] t, v;
      logic d;
      logic [2:0] s;
      logic [5:0] p;
      logic [2:0] rq;
   } vec_t;
   logic clk = 1'b0, rst = 1'b0, tick = 1'b0;
   logic disc, fatal, ign, dlv, rsd, upd;
   logic [2:0] disc_host, ev_host, qstate;
   logic [2:0] qhost = 3'd0;
   int n_cmp = 0, n_bad = 0;
   logic [5:0] rq_q[$];
   vec_t tbl[15];
   fix_session_engine_if #(.HOST_W(3)) bus();
   fix_session_engine #(.NUM_SESSIONS(8), .HOST_W(3), .HB_INTERVAL(3), .REQ_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus), .tick_i(tick),
      .disconnect_o(disc), .disconnect_host_o(disc_host), .fatal_o(fatal),
      .ignore_o(ign), .deliver_o(dlv), .do_resend_o(rsd), .update_seq_o(upd),
      .event_host_o(ev_host), .query_host_i(qhost), .query_state_o(qstate)
   );
   always #5 clk = ~clk;
   always @(posedge clk)
      if (bus.req_valid_o && bus.req_ready_i) rq_q.push_back({bus.req_type_o, bus.req_host_o});
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic chk_state(input string name, input logic [2:0] h, input logic [2:0] exp);
      qhost = h;
      #1;
      chk(name, 32'(qstate), 32'(exp));
   endtask
   function automatic logic [31:0] qhead();
      return rq_q.size() == 0 ? 32'h0 : (32'(rq_q.size()) << 8) | 32'(rq_q[0]);
   endfunction
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      tick = 1'b0;
      bus.msg_valid_i = 1'b0;
      bus.cmd_valid_i = 1'b0;
      bus.req_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      rq_q.delete();
   endtask
   task automatic send_msg(input logic [2:0] h, input logic [2:0] t, input logic [2:0] v, input logic d);
      @(negedge clk);
      bus.msg_host_i = h;
      bus.msg_type_i = t;
      bus.msg_validity_i = v;
      bus.resend_done_i = d;
      bus.msg_valid_i = 1'b1;
      @(negedge clk);
      bus.msg_valid_i = 1'b0;
      bus.resend_done_i = 1'b0;
   endtask
   task automatic send_cmd(input logic [2:0] h, input logic op);
      @(negedge clk);
      bus.cmd_host_i = h;
      bus.cmd_op_i = op;
      bus.cmd_valid_i = 1'b1;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
   endtask
   task automatic tick_once();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask
   initial begin
      logic got;
      tbl = '{
         '{3'd1, 3'd0, 1'b0, 3'd2, 6'b000000, 3'd0},
         '{3'd2, 3'd0, 1'b0, 3'd2, 6'b000000, 3'd0},
         '{3'd7, 3'd0, 1'b0, 3'd2, 6'b010000, 3'd0},
         '{3'd7, 3'd2, 1'b0, 3'd2, 6'b100000, 3'd0},
         '{3'd3, 3'd0, 1'b0, 3'd2, 6'b001000, 3'd0},
         '{3'd7, 3'd1, 1'b0, 3'd4, 6'b000000, 3'd3},
         '{3'd6, 3'd0, 1'b0, 3'd4, 6'b000100, 3'd0},
         '{3'd7, 3'd0, 1'b0, 3'd4, 6'b010000, 3'd0},
         '{3'd5, 3'd1, 1'b0, 3'd4, 6'b000100, 3'd0},
         '{3'd6, 3'd0, 1'b1, 3'd2, 6'b000100, 3'd0},
         '{3'd4, 3'd1, 1'b0, 3'd5, 6'b000000, 3'd3},
         '{3'd6, 3'd0, 1'b1, 3'd6, 6'b000100, 3'd4},
         '{3'd3, 3'd0, 1'b0, 3'd6, 6'b001000, 3'd0},
         '{3'd4, 3'd0, 1'b0, 3'd0, 6'b000010, 3'd0},
         '{3'd2, 3'd0, 1'b0, 3'd0, 6'b100000, 3'd0}
      };
      {bus.msg_valid_i, bus.resend_done_i, bus.cmd_valid_i, bus.cmd_op_i} = '0;
      {bus.msg_host_i, bus.msg_type_i, bus.msg_validity_i, bus.cmd_host_i} = '0;
      bus.req_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_msg_ready", 32'(bus.msg_ready_o), 0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 0);
      chk("rst_req_valid", 32'(bus.req_valid_o), 0);
      chk("rst_pulses", 32'({ign, dlv, rsd, upd, disc, fatal}), 0);
      for (int h = 0; h < 8; h++) chk_state($sformatf("rst_state%0d", h), 3'(h), 3'd0);
      @(negedge clk);
      rst = 1'b1;
      send_cmd(3'd3, 1'b0);
      chk_state("A_logon_sent", 3'd3, 3'd1);
      send_msg(3'd3, 3'd1, 3'd0, 1'b0);
      chk_state("A_active", 3'd3, 3'd2);
      @(negedge clk);
      chk("A_req", qhead(), 32'h100 | 32'({3'd1, 3'd3}));
      do_reset();
      send_cmd(3'd2, 1'b0);
      @(negedge clk);
      rq_q.delete();
      foreach (tbl[i]) begin
         send_msg(3'd2, tbl[i].t, tbl[i].v, tbl[i].d);
         chk($sformatf("vec%0d_pulse", i), 32'({ign, dlv, rsd, upd, disc, fatal}), 32'(tbl[i].p));
         chk($sformatf("vec%0d_host", i), 32'({ev_host, disc_host}),
             32'({(|tbl[i].p[5:2]) ? 3'd2 : 3'd0, tbl[i].p[1] ? 3'd2 : 3'd0}));
         chk_state($sformatf("vec%0d_state", i), 3'd2, tbl[i].s);
         @(negedge clk);
         chk($sformatf("vec%0d_req", i), qhead(), tbl[i].rq == 3'd0 ? 32'h0 : 32'h100 | 32'({tbl[i].rq, 3'd2}));
         rq_q.delete();
      end
      do_reset();
      send_cmd(3'd1, 1'b0);
      send_msg(3'd1, 3'd1, 3'd0, 1'b0);
      @(negedge clk);
      rq_q.delete();
      repeat (3) tick_once();
      @(negedge clk);
      chk_state("C_hb_sent", 3'd1, 3'd3);
      @(negedge clk);
      chk("C_hb_req", qhead(), 32'h100 | 32'({3'd2, 3'd1}));
      rq_q.delete();
      repeat (2) tick_once();
      chk_state("C_still_hb", 3'd1, 3'd3);
      tick_once();
      @(negedge clk);
      chk("C_disc", 32'({disc, fatal, disc_host}), 32'({1'b1, 1'b0, 3'd1}));
      chk_state("C_state", 3'd1, 3'd0);
      do_reset();
      bus.req_ready_i = 1'b0;
      for (int h = 0; h < 4; h++) send_cmd(3'(h), 1'b0);
      @(negedge clk);
      bus.cmd_host_i = 3'd4;
      bus.cmd_op_i = 1'b0;
      bus.cmd_valid_i = 1'b1;
      #1;
      chk("D_full_cmd_ready", 32'(bus.cmd_ready_o), 0);
      chk("D_full_msg_ready", 32'(bus.msg_ready_o), 0);
      chk("D_req_head", 32'({bus.req_valid_o, bus.req_type_o, bus.req_host_o}), 32'({1'b1, 3'd1, 3'd0}));
      repeat (3) @(negedge clk);
      chk("D_req_stable", 32'({bus.req_valid_o, bus.req_type_o, bus.req_host_o}), 32'({1'b1, 3'd1, 3'd0}));
      bus.req_ready_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         got = bus.cmd_ready_o;
         @(negedge clk);
      end
      bus.cmd_valid_i = 1'b0;
      chk("D_accept", 32'(got), 1);
      repeat (8) @(negedge clk);
      chk("D_count", rq_q.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("D_req%0d", i), 32'(rq_q.size() > i ? rq_q[i] : 6'h3f), 32'({3'd1, 3'(i)}));
      do_reset();
      send_cmd(3'd5, 1'b0);
      send_msg(3'd5, 3'd1, 3'd0, 1'b0);
      send_msg(3'd5, 3'd7, 3'd3, 1'b0);
      chk("E_fatal", 32'({disc, fatal, disc_host}), 32'({1'b1, 1'b1, 3'd5}));
      chk_state("E_state", 3'd5, 3'd0);
      send_msg(3'd5, 3'd2, 3'd0, 1'b0);
      chk("E_ignore", 32'({ign, dlv, rsd, upd, disc, fatal, ev_host}), 32'({6'b100000, 3'd5}));
      do_reset();
      bus.req_ready_i = 1'b0;
      send_cmd(3'd2, 1'b0);
      send_msg(3'd2, 3'd1, 3'd0, 1'b0);
      send_msg(3'd2, 3'd7, 3'd1, 1'b0);
      chk_state("F_resend", 3'd2, 3'd4);
      chk("F_req_valid", 32'(bus.req_valid_o), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("F_rst_ready", 32'({bus.msg_ready_o, bus.cmd_ready_o}), 0);
      @(negedge clk);
      chk("F_rst_req_valid", 32'(bus.req_valid_o), 0);
      for (int h = 0; h < 8; h++) chk_state($sformatf("F_state%0d", h), 3'(h), 3'd0);
      rst = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fix_session_engine.md
# fix_session_engine

Multi-session FIX session-layer controller: holds per-session protocol state, per-session heartbeat/test timers and an outbound message-request queue. It sits between the inbound message validator (sequence/CompID checks) and the message creator. It replaces single-event handling with arbitrated inbound, command and timer events and a ready/valid request interface, so no request is lost while the creator is busy.

## Interface
- NUM_SESSIONS, 8: number of sessions (≥2).
- HOST_W, 3: session index width, ≥ clog2(NUM_SESSIONS).
- HB_INTERVAL, 30: heartbeat interval in tick_i pulses (1..255).
- REQ_DEPTH, 4: outbound request FIFO depth (power of two, ≥2).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- msg_valid_i  in  1  inbound message event.
- msg_ready_o  out  1  inbound event accepted this cycle.
- msg_host_i  in  HOST_W  session index of inbound message.
- msg_type_i  in  3  1 logon, 2 heartbeat, 3 resendReq, 4 logout, 5 reset, 6 gapFill, 7 business.
- msg_validity_i  in  3  0 valid, 1 seqHigh, 2 garbled, 3 seqLow, 4 invalid.
- resend_done_i  in  1  qualifies msg event: gap fully recovered.
- cmd_valid_i  in  1  local command event.
- cmd_ready_o  out  1  command accepted.
- cmd_host_i  in  HOST_W  command target session.
- cmd_op_i  in  1  0 connect (send logon), 1 end session (send logout).
- tick_i  in  1  one-cycle timebase pulse.
- req_valid_o / req_ready_i  out/in  1  request to message creator; transfer when both high.
- req_type_o  out  3  message type to create (1,2,3,4 only).
- req_host_o  out  HOST_W  target session.
- disconnect_o  out  1  one-cycle pulse: drop session.
- disconnect_host_o  out  HOST_W  session dropped.
- fatal_o  out  1  with disconnect_o: seqLow/invalid cause.
- ignore_o, deliver_o, do_resend_o, update_seq_o  out  1  one-cycle pulses for the accepted msg event (drop, pass business msg up, serve resend, apply gapFill/reset).
- event_host_o  out  HOST_W  host for the four pulses above.
- query_host_i  in  HOST_W  / query_state_o  out  3  combinational state readback.

## Operation
- States: DISC 0, LOGON_SENT 1, ACTIVE 2, HB_SENT 3, RESEND 4, RESEND_LOGOUT 5, LOGOUT_SENT 6.
- Arbitration, one event per cycle: msg > cmd > timeout. Nothing is accepted unless the FIFO has a free slot (accepted event may push ≤1 request). msg_ready_o = rst & !full; cmd_ready_o = rst & !full & !msg_valid_i.
- Message on DISC session: ignore_o only. Otherwise seqLow/invalid in any state: disconnect_o, fatal_o, → DISC.
- Garbled in any non-DISC state: ignore_o, no state change, timer not reloaded.
- LOGON_SENT: logon/valid → ACTIVE; logon/seqHigh → push resendReq, → RESEND; else disconnect → DISC.
- ACTIVE/HB_SENT: logout/valid → push logout, disconnect, → DISC; logout/seqHigh → push resendReq, → RESEND_LOGOUT; resendReq → do_resend_o, → ACTIVE; other seqHigh → push resendReq, → RESEND; heartbeat → ACTIVE; business → deliver_o, → ACTIVE.
- RESEND / RESEND_LOGOUT: gapFill or reset → update_seq_o; seqHigh non-reset → push resendReq; business → deliver_o. If resend_done_i: RESEND → ACTIVE, RESEND_LOGOUT → push logout, → LOGOUT_SENT (resend_done overrides the seqHigh push).
- LOGOUT_SENT: logout → disconnect, → DISC; resendReq → do_resend_o, stay; else disconnect → DISC.
- Cmd connect: any state → push logon, → LOGON_SENT, timer reload. Cmd end: DISC → no action; else push logout, → LOGOUT_SENT, reload.
- Timers: 8-bit per session, held at 0 in DISC. Any non-garbled accepted message reloads HB_INTERVAL. tick_i decrements all non-DISC nonzero counters; reaching 0 sets session pending flag.
- Timeout service: round-robin pointer from last serviced+1, lowest pending index found. LOGON_SENT/LOGOUT_SENT/HB_SENT → disconnect, → DISC. ACTIVE → push heartbeat, → HB_SENT. RESEND* → push heartbeat, stay. Clear flag, reload.
- Pending flag cleared when a message/cmd for that session is accepted first.

## Timing
- Reset: all sessions DISC, timers 0, flags clear, FIFO empty, pointer 0; every registered output 0; ready outputs 0 while rst low.
- Event accepted cycle N: pulses, disconnect and state update visible N+1; FIFO push at N, req_valid_o high N+1 if FIFO was empty.
- FIFO full: push impossible by construction; req_* stable while req_valid_o & !req_ready_i.
- Simultaneous push/pop at full/empty legal; occupancy unchanged.
- tick_i coinciding with reload on same session: reload wins.

## Test plan
- Connect host 3, reply logon/valid -> one req {1,3}, query_state_o(3)=2 after N+1.
- Host 2 ACTIVE, business/seqHigh -> req {3,2}, state 4; then gapFill + resend_done_i -> update_seq_o, state 2.
- HB_INTERVAL=3, host 1 idle: 3 ticks -> req {2,1}, state 3; 3 more ticks -> disconnect_o, disconnect_host_o=1, state 0.
- req_ready_i=0, sessions 0-4 connected -> 4 requests queued, cmd_ready_o=0 at 5th; release -> remaining logon emitted in order.
- Host 5 ACTIVE, seqLow -> disconnect_o and fatal_o same cycle, state 0; later message to host 5 -> ignore_o only.
- Assert rst low mid-resend with FIFO nonempty -> next cycle req_valid_o=0, all states 0.
